// File: rtl/axis_image_pattern_src.sv
// AXI4-Stream raster pattern generator: emits IMG_WIDTH x IMG_HEIGHT frames with
// tuser on pixel (0,0) and tlast on every line end, optional inter-frame gap.
module axis_image_pattern_src #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned IMG_WIDTH  = 64,
  parameter int unsigned IMG_HEIGHT = 48,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [1:0]           mode_i,
  input  logic [15:0]          num_frames_i,
  output logic [DATA_BITS-1:0] axis_m_data_o,
  output logic                 axis_m_valid_o,
  input  logic                 axis_m_ready_i,
  output logic                 axis_m_last_o,
  output logic                 axis_m_user_o,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic [15:0]          frame_cnt_o
);

  localparam int unsigned XW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned YW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned XLAST = IMG_WIDTH - 1;
  localparam int unsigned YLAST = IMG_HEIGHT - 1;
  localparam int unsigned GLAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic [XW-1:0]        r_x;
  logic [YW-1:0]        r_y;
  logic [GW-1:0]        r_gap_cnt;
  logic [1:0]           r_mode;
  logic [15:0]          r_num_frames;
  logic [15:0]          r_frame_cnt;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_last;
  logic                 r_user;
  logic                 r_busy;
  logic                 r_frame_done;

  // Pixel value for a given pattern and raster position.
  function automatic logic [DATA_BITS-1:0] f_pix(input logic [1:0]    mode,
                                                 input logic [XW-1:0] x,
                                                 input logic [YW-1:0] y);
    logic [31:0] xe;
    logic [31:0] ye;
    xe = 32'(x);
    ye = 32'(y);
    case (mode)
      2'd0:    f_pix = DATA_BITS'(xe);
      2'd1:    f_pix = DATA_BITS'(ye);
      2'd2:    f_pix = (xe[3] ^ ye[3]) ? {DATA_BITS{1'b1}} : {DATA_BITS{1'b0}};
      default: f_pix = DATA_BITS'(ye * 32'(IMG_WIDTH) + xe);
    endcase
  endfunction

  logic                 w_accept;
  logic                 w_x_end;
  logic                 w_y_end;
  logic [XW-1:0]        w_nx;
  logic [YW-1:0]        w_ny;
  logic [15:0]          w_cnt_inc;
  logic                 w_run_over;
  logic [DATA_BITS-1:0] w_start_data;
  logic [DATA_BITS-1:0] w_next_data;

  assign w_accept     = r_valid & axis_m_ready_i;
  assign w_x_end      = (r_x == XW'(XLAST));
  assign w_y_end      = (r_y == YW'(YLAST));
  assign w_nx         = w_x_end ? '0 : r_x + XW'(1);
  assign w_ny         = w_x_end ? r_y + YW'(1) : r_y;
  assign w_cnt_inc    = r_frame_cnt + 16'd1;
  assign w_run_over   = (r_num_frames != 16'd0) && (w_cnt_inc == r_num_frames);
  assign w_start_data = f_pix(mode_i, '0, '0);
  assign w_next_data  = f_pix(r_mode, w_nx, w_ny);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_gap_cnt    <= '0;
      r_mode       <= 2'd0;
      r_num_frames <= 16'd0;
      r_frame_cnt  <= 16'd0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_last       <= 1'b0;
      r_user       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (enable_i) begin
            r_mode       <= mode_i;
            r_num_frames <= num_frames_i;
            r_frame_cnt  <= 16'd0;
            r_x          <= '0;
            r_y          <= '0;
            r_data       <= w_start_data;
            r_valid      <= 1'b1;
            r_user       <= 1'b1;
            r_last       <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (w_accept) begin
            if (w_x_end && w_y_end) begin
              r_frame_done <= 1'b1;
              r_frame_cnt  <= w_cnt_inc;
              r_x          <= '0;
              r_y          <= '0;
              r_last       <= 1'b0;
              r_user       <= 1'b0;
              if (w_run_over) begin
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
                r_state <= ST_DONE;
              end else if (!enable_i) begin
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
              end else if (GAP_CYCLES == 0) begin
                // Back-to-back frame: valid stays high, next frame starts now.
                r_mode  <= mode_i;
                r_data  <= w_start_data;
                r_user  <= 1'b1;
              end else begin
                r_valid   <= 1'b0;
                r_gap_cnt <= '0;
                r_state   <= ST_GAP;
              end
            end else begin
              r_x    <= w_nx;
              r_y    <= w_ny;
              r_data <= w_next_data;
              r_last <= (w_nx == XW'(XLAST));
              r_user <= 1'b0;
            end
          end
        end

        ST_GAP: begin
          if (r_gap_cnt == GW'(GLAST)) begin
            if (enable_i) begin
              r_mode  <= mode_i;
              r_data  <= w_start_data;
              r_valid <= 1'b1;
              r_user  <= 1'b1;
              r_last  <= 1'b0;
              r_state <= ST_RUN;
            end else begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end

        default: begin
          // Run finished: wait for enable to fall before a new run can begin.
          if (!enable_i) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign axis_m_data_o  = r_data;
  assign axis_m_valid_o = r_valid;
  assign axis_m_last_o  = r_last;
  assign axis_m_user_o  = r_user;
  assign busy_o         = r_busy;
  assign frame_done_o   = r_frame_done;
  assign frame_cnt_o    = r_frame_cnt;

endmodule

// File: tb/tb_axis_image_pattern_src.sv
// Randomized self-checking bench for axis_image_pattern_src against a raster model.
module tb_axis_image_pattern_src;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int NB = W * H;
  localparam int WB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] nf = 16'd0;
  logic        ready = 1'b0;
  logic [7:0]  data;
  logic        valid, last, user, busy, fd;
  logic [15:0] cnt;

  logic        b_en = 1'b0;
  logic [1:0]  b_mode = 2'd0;
  logic [15:0] b_nf = 16'd0;
  logic        b_rdy = 1'b0;
  logic [7:0]  b_data;
  logic        b_valid, b_last, b_user, b_busy, b_fd;
  logic [15:0] b_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  axis_image_pattern_src #(.DATA_BITS(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .GAP_CYCLES(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .mode_i(mode), .num_frames_i(nf),
    .axis_m_data_o(data), .axis_m_valid_o(valid), .axis_m_ready_i(ready),
    .axis_m_last_o(last), .axis_m_user_o(user), .busy_o(busy),
    .frame_done_o(fd), .frame_cnt_o(cnt)
  );

  axis_image_pattern_src #(.DATA_BITS(8), .IMG_WIDTH(WB), .IMG_HEIGHT(2), .GAP_CYCLES(0)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(b_en), .mode_i(b_mode), .num_frames_i(b_nf),
    .axis_m_data_o(b_data), .axis_m_valid_o(b_valid), .axis_m_ready_i(b_rdy),
    .axis_m_last_o(b_last), .axis_m_user_o(b_user), .busy_o(b_busy),
    .frame_done_o(b_fd), .frame_cnt_o(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference pixel value straight from the pattern definitions.
  function automatic int exp_pix(input int m, input int x, input int y, input int w);
    case (m)
      0:       return x % 256;
      1:       return y % 256;
      2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 255 : 0;
      default: return (y * w + x) % 256;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consume one frame on DUT A with random backpressure; checks every valid cycle.
  task automatic chk_frame(input int m, input int pct, input int drop_at,
                           input int chg_at, input int chg_mode, input int exp_cnt);
    int k;
    int cyc;
    k = 0;
    cyc = 0;
    while (k < NB && cyc < 200) begin
      ready = ($urandom_range(0, 99) < pct);
      check("valid_mid", valid, 1);
      check("fd_mid", fd, 0);
      if (valid) begin
        check("data", data, exp_pix(m, k % W, k / W, W));
        check("last", last, (k % W) == W - 1);
        check("user", user, k == 0);
        if (ready) begin
          if (k == drop_at) enable = 1'b0;
          if (k == chg_at) mode = 2'(chg_mode);
          k++;
        end
      end
      tick();
      cyc++;
    end
    if (k < NB) check("frame_timeout", k, NB);
    check("frame_done", fd, 1);
    check("frame_cnt", cnt, exp_cnt);
    check("valid_end", valid, 0);
  endtask

  // Count idle cycles from the current (first post-frame) cycle up to the next beat.
  task automatic chk_gap(input int exp);
    int n;
    n = 0;
    while (!valid && n < 20) begin
      n++;
      tick();
    end
    check("gap_len", n, exp);
  endtask

  task automatic chk_quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check(tag, valid, 0);
      check("busy_quiet", busy, 0);
      tick();
    end
  endtask

  initial begin
    int m1, m2, m3;
    repeat (3) tick();
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fd", fd, 0);
    check("rst_cnt", cnt, 0);
    check("rst_data", data, 0);
    check("rst_last", last, 0);
    check("rst_user", user, 0);
    rst = 1'b0;
    tick();

    // Single frame, full throughput, then DONE until enable falls
    mode = 2'd0; nf = 16'd1; ready = 1'b1; enable = 1'b1;
    tick();
    check("first_valid", valid, 1);
    check("busy_run", busy, 1);
    chk_frame(0, 100, -1, -1, 0, 1);
    chk_quiet("done_valid", 4);
    enable = 1'b0;
    tick();

    // Random backpressure on the beat-index pattern
    mode = 2'd3; nf = 16'd1; enable = 1'b1;
    tick();
    chk_frame(3, 50, -1, -1, 0, 1);
    enable = 1'b0;
    tick();

    // Three-frame run with gaps and per-frame random modes
    m1 = $urandom_range(0, 3); m2 = $urandom_range(0, 3); m3 = $urandom_range(0, 3);
    mode = 2'(m1); nf = 16'd3; enable = 1'b1;
    tick();
    chk_frame(m1, 70, -1, -1, 0, 1);
    mode = 2'(m2);
    check("busy_gap", busy, 1);
    chk_gap(2);
    chk_frame(m2, 70, -1, -1, 0, 2);
    mode = 2'(m3);
    chk_gap(2);
    chk_frame(m3, 70, -1, -1, 0, 3);
    chk_quiet("after_last", 5);
    enable = 1'b0;
    tick();

    // Unbounded run: mid-frame mode change, then graceful stop in frame 2
    mode = 2'd1; nf = 16'd0; enable = 1'b1;
    tick();
    chk_frame(1, 60, -1, 3, 2, 1);
    chk_gap(2);
    chk_frame(2, 60, 2, -1, 0, 2);
    chk_quiet("stop_valid", 6);

    // Reset in the middle of the second frame, then restart
    m1 = $urandom_range(0, 3);
    mode = 2'(m1); nf = 16'd0; enable = 1'b1;
    tick();
    chk_frame(m1, 100, -1, -1, 0, 1);
    chk_gap(2);
    ready = 1'b1;
    repeat (5) tick();
    check("pre_rst_data", data, exp_pix(m1, 1, 1, W));
    check("pre_rst_cnt", cnt, 1);
    rst = 1'b1;
    tick();
    check("midrst_valid", valid, 0);
    check("midrst_cnt", cnt, 0);
    check("midrst_busy", busy, 0);
    check("midrst_fd", fd, 0);
    rst = 1'b0;
    m2 = $urandom_range(0, 3);
    mode = 2'(m2);
    tick();
    check("restart_user", user, 1);
    chk_frame(m2, 80, 0, -1, 0, 1);
    chk_quiet("restart_stop", 3);

    // Zero-gap variant: two back-to-back frames, mode re-sampled at the boundary
    b_mode = 2'd2; b_nf = 16'd2; b_rdy = 1'b1; b_en = 1'b1;
    tick();
    for (int k = 0; k < 2 * WB * 2; k++) begin
      check("b_valid", b_valid, 1);
      check("b_data", b_data, exp_pix((k < 2 * WB) ? 2 : 0, k % WB, (k / WB) % 2, WB));
      check("b_last", b_last, (k % WB) == WB - 1);
      check("b_user", b_user, (k % (2 * WB)) == 0);
      check("b_fd", b_fd, k == 2 * WB);
      if (k == 20) b_mode = 2'd0;
      tick();
    end
    check("b_fd_end", b_fd, 1);
    check("b_cnt", b_cnt, 2);
    check("b_valid_end", b_valid, 0);
    tick();
    check("b_busy_end", b_busy, 0);
    b_en = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
